bin_div: RTL and testbench

// - Iterative radix-2 restoring unsigned divider, the inverse of bin_mult: (2W)-bit dividend / W-bit divisor -> W-bit quotient + W-bit remainder.
// - Takes a bin_mult product C and a factor B and recovers the other factor A.
// - Valid/ready handshake on both sides; one operation in flight; one quotient bit per clock.

---
 rtl/bin_div_pkg.sv | 14 +
 rtl/bin_div_step.sv | 32 +++
 rtl/bin_div.sv | 135 +++++++++++++
 tb/tb_bin_div.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/bin_div_pkg.sv
// Shared definitions for the bin_div restoring divider.
//   bin_div_state_t : FSM encoding (IDLE, CALC, DONE)
//   DIV_WIDTH       : default divisor/quotient/remainder width
package bin_div_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } bin_div_state_t;

  localparam int unsigned DIV_WIDTH = 32;

endpackage

// File: rtl/bin_div_step.sv
// One radix-2 restoring division step (purely combinational).
// Ports:
//   r       in   WIDTH  current partial remainder (always < divisor)
//   q_msb   in   1      next dividend bit shifted into the remainder
//   divisor in   WIDTH  divisor
//   r_next  out  WIDTH  partial remainder after this step
//   q_bit   out  1      quotient bit produced by this step
module bin_div_step #(
  parameter int unsigned WIDTH = 32
) (
  input  logic [WIDTH-1:0] r,
  input  logic             q_msb,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] r_next,
  output logic             q_bit
);

  logic [WIDTH:0] t;

  always_comb begin
    t      = {r, q_msb};
    q_bit  = 1'b0;
    r_next = t[WIDTH-1:0];
    if (t >= {1'b0, divisor}) begin
      q_bit  = 1'b1;
      // True difference is < divisor, so it fits WIDTH bits and equals the
      // modulo-2^WIDTH difference of the low bits.
      r_next = t[WIDTH-1:0] - divisor;
    end
  end

endmodule

// File: rtl/bin_div.sv
// Iterative radix-2 restoring unsigned divider: (2*WIDTH)-bit dividend by
// WIDTH-bit divisor, one quotient bit per clock, one operation in flight.
// Ports:
//   CLK          in   1          clock (rising edge)
//   rst_n        in   1          asynchronous active-low reset
//   in_valid     in   1          operands valid
//   in_ready     out  1          divider can accept (IDLE and out of reset)
//   dividend     in   2*WIDTH    unsigned dividend, sampled on accept
//   divisor      in   WIDTH      unsigned divisor, sampled on accept
//   out_valid    out  1          result valid (DONE)
//   out_ready    in   1          consumer takes result
//   quotient     out  WIDTH      quotient
//   remainder    out  WIDTH      remainder
//   div_by_zero  out  1          divisor was zero (qualified by out_valid)
//   overflow     out  1          quotient exceeds WIDTH bits (qualified by out_valid)
module bin_div
  import bin_div_pkg::*;
#(
  parameter int unsigned WIDTH = DIV_WIDTH
) (
  input  logic               CLK,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [2*WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0]   divisor,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   quotient,
  output logic [WIDTH-1:0]   remainder,
  output logic               div_by_zero,
  output logic               overflow
);

  localparam int unsigned CW = $clog2(WIDTH + 1);

  bin_div_state_t   state, state_nx;
  logic [WIDTH-1:0] r_reg, r_nx;
  logic [WIDTH-1:0] q_reg, q_nx;
  logic [WIDTH-1:0] d_reg, d_nx;
  logic [CW-1:0]    count, count_nx;
  logic             dbz_reg, dbz_nx;
  logic             ovf_reg, ovf_nx;

  logic [WIDTH-1:0] step_r;
  logic             step_q;

  bin_div_step #(.WIDTH(WIDTH)) u_step (
    .r       (r_reg),
    .q_msb   (q_reg[WIDTH-1]),
    .divisor (d_reg),
    .r_next  (step_r),
    .q_bit   (step_q)
  );

  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      r_reg   <= '0;
      q_reg   <= '0;
      d_reg   <= '0;
      count   <= '0;
      dbz_reg <= 1'b0;
      ovf_reg <= 1'b0;
    end else begin
      state   <= state_nx;
      r_reg   <= r_nx;
      q_reg   <= q_nx;
      d_reg   <= d_nx;
      count   <= count_nx;
      dbz_reg <= dbz_nx;
      ovf_reg <= ovf_nx;
    end
  end

  always_comb begin
    state_nx = state;
    r_nx     = r_reg;
    q_nx     = q_reg;
    d_nx     = d_reg;
    count_nx = count;
    dbz_nx   = dbz_reg;
    ovf_nx   = ovf_reg;

    unique case (state)
      IDLE: begin
        if (in_valid) begin
          d_nx = divisor;
          if (divisor == '0) begin
            state_nx = DONE;
            dbz_nx   = 1'b1;
            q_nx     = '1;
            r_nx     = dividend[WIDTH-1:0];
          end else if (dividend[2*WIDTH-1:WIDTH] >= divisor) begin
            // Quotient would not fit WIDTH bits; this pre-check also keeps
            // the partial remainder below the divisor for every CALC step.
            state_nx = DONE;
            ovf_nx   = 1'b1;
            q_nx     = '1;
            r_nx     = '0;
          end else begin
            state_nx = CALC;
            r_nx     = dividend[2*WIDTH-1:WIDTH];
            q_nx     = dividend[WIDTH-1:0];
            count_nx = CW'(WIDTH);
          end
        end
      end
      CALC: begin
        r_nx     = step_r;
        q_nx     = {q_reg[WIDTH-2:0], step_q};
        count_nx = count - 1'b1;
        if (count == CW'(1)) begin
          state_nx = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_nx = IDLE;
          dbz_nx   = 1'b0;
          ovf_nx   = 1'b0;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  assign in_ready    = rst_n && (state == IDLE);
  assign out_valid   = (state == DONE);
  assign quotient    = q_reg;
  assign remainder   = r_reg;
  assign div_by_zero = dbz_reg;
  assign overflow    = ovf_reg;

endmodule

// File: tb/tb_bin_div.sv
module tb_bin_div;

  localparam int unsigned W = 32;

  logic           CLK = 1'b0;
  logic           rst_n;
  logic           in_valid;
  logic           in_ready;
  logic [2*W-1:0] dividend;
  logic [W-1:0]   divisor;
  logic           out_valid;
  logic           out_ready;
  logic [W-1:0]   quotient;
  logic [W-1:0]   remainder;
  logic           div_by_zero;
  logic           overflow;

  bin_div #(.WIDTH(W)) dut (
    .CLK         (CLK),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .dividend    (dividend),
    .divisor     (divisor),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero),
    .overflow    (overflow)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [2*W-1:0] dd;
    logic [W-1:0]   dv;
    logic [W-1:0]   q;
    logic [W-1:0]   r;
    logic           dbz;
    logic           ovf;
    int             lat;  // edges after the accept edge until out_valid is seen
  } vec_t;

  typedef struct {
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         dbz;
    logic         ovf;
  } res_t;

  res_t sb[$];
  int   checks   = 0;
  int   failures = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic [2*W-1:0] dd, input logic [W-1:0] dv,
                              input logic [W-1:0] q, input logic [W-1:0] r,
                              input logic dbz, input logic ovf);
    vec_t v;
    v.dd = dd; v.dv = dv; v.q = q; v.r = r; v.dbz = dbz; v.ovf = ovf;
    v.lat = (dbz || ovf) ? 0 : W;
    return v;
  endfunction

  // Reference model using plain wide arithmetic.
  function automatic vec_t model(input logic [2*W-1:0] dd, input logic [W-1:0] dv);
    logic [2*W-1:0] q64;
    logic [2*W-1:0] r64;
    if (dv == '0) return mk(dd, dv, '1, dd[W-1:0], 1'b1, 1'b0);
    if (dd[2*W-1:W] >= dv) return mk(dd, dv, '1, '0, 1'b0, 1'b1);
    q64 = dd / {32'd0, dv};
    r64 = dd % {32'd0, dv};
    return mk(dd, dv, q64[W-1:0], r64[W-1:0], 1'b0, 1'b0);
  endfunction

  task automatic check_reset_outputs(input string tag);
    check({tag, "_quotient"},  64'(quotient),    64'd0);
    check({tag, "_remainder"}, 64'(remainder),   64'd0);
    check({tag, "_out_valid"}, 64'(out_valid),   64'd0);
    check({tag, "_in_ready"},  64'(in_ready),    64'd0);
    check({tag, "_dbz"},       64'(div_by_zero), 64'd0);
    check({tag, "_ovf"},       64'(overflow),    64'd0);
  endtask

  // Called mid-cycle with the DUT in IDLE; returns mid-cycle after the accept edge.
  task automatic start_op(input string tag, input vec_t v);
    res_t e;
    in_valid = 1'b1;
    dividend = v.dd;
    divisor  = v.dv;
    check({tag, "_in_ready"}, 64'(in_ready), 64'd1);
    @(posedge CLK);
    e.q = v.q; e.r = v.r; e.dbz = v.dbz; e.ovf = v.ovf;
    sb.push_back(e);
    #1;
    in_valid = 1'b0;
    dividend = {$urandom, $urandom};
    divisor  = $urandom;
  endtask

  task automatic wait_done(input string tag, input int exp_lat);
    int lat = 0;
    while (!out_valid && lat < 200) begin
      if (in_ready) begin
        checks++; failures++;
        $display("FAIL %s_busy_ready in_ready=1 required=0 at cycle %0d", tag, lat);
      end
      @(posedge CLK); #1;
      lat++;
    end
    check({tag, "_latency"}, 64'(lat), 64'(exp_lat));
  endtask

  task automatic compare_out(input string tag);
    res_t e;
    if (sb.size() == 0) begin
      checks++; failures++;
      $display("FAIL %s_scoreboard actual=empty required=entry", tag);
    end else begin
      e = sb.pop_front();
      check({tag, "_quotient"},  64'(quotient),    64'(e.q));
      check({tag, "_remainder"}, 64'(remainder),   64'(e.r));
      check({tag, "_dbz"},       64'(div_by_zero), 64'(e.dbz));
      check({tag, "_ovf"},       64'(overflow),    64'(e.ovf));
    end
  endtask

  task automatic finish_xfer(input string tag);
    out_ready = 1'b1;
    @(posedge CLK); #1;
    check({tag, "_idle_valid"}, 64'(out_valid), 64'd0);
    check({tag, "_idle_ready"}, 64'(in_ready),  64'd1);
  endtask

  task automatic run_vec(input string tag, input vec_t v);
    start_op(tag, v);
    wait_done(tag, v.lat);
    compare_out(tag);
    finish_xfer(tag);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[10];
    vec_t v;
    logic [W-1:0] a, b, rdv;

    a = 32'h1234_5678;
    b = 32'h9ABC_DEF0;
    vecs[0] = mk(64'd100, 32'd7, 32'd14, 32'd2, 1'b0, 1'b0);
    vecs[1] = mk(64'hFFFF_FFFE_0000_0001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 1'b0, 1'b0);
    vecs[2] = mk({32'd0, a} * {32'd0, b}, b, a, 32'd0, 1'b0, 1'b0);
    vecs[3] = mk(64'h1234_5678_9ABC_DEF0, 32'd0, 32'hFFFF_FFFF, 32'h9ABC_DEF0, 1'b1, 1'b0);
    vecs[4] = mk(64'd0, 32'd0, 32'hFFFF_FFFF, 32'd0, 1'b1, 1'b0);
    vecs[5] = mk(64'h0000_0001_0000_0000, 32'd1, 32'hFFFF_FFFF, 32'd0, 1'b0, 1'b1);
    vecs[6] = mk(64'h0000_0007_0000_0000, 32'd7, 32'hFFFF_FFFF, 32'd0, 1'b0, 1'b1);
    vecs[7] = mk(64'h0000_0006_FFFF_FFFF, 32'd7, 32'hFFFF_FFFF, 32'd6, 1'b0, 1'b0);
    for (int i = 8; i < 10; i++) begin
      rdv = $urandom_range(32'hFFFF_FFFF, 32'd2);
      vecs[i] = model({32'($urandom_range(rdv - 1, 0)), 32'($urandom)}, rdv);
    end

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    dividend  = '0;
    divisor   = '0;
    repeat (3) @(posedge CLK);
    #1;
    check_reset_outputs("reset");
    rst_n = 1'b1;
    #1;
    check("reset_release_in_ready", 64'(in_ready), 64'd1);
    @(posedge CLK); #1;

    for (int i = 0; i < 10; i++) begin
      run_vec($sformatf("vec%0d", i), vecs[i]);
    end

    // Result held while the consumer stalls; new requests ignored in DONE.
    out_ready = 1'b0;
    start_op("hold", vecs[0]);
    wait_done("hold", W);
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1;
      dividend = 64'd1000;
      divisor  = 32'd3;
      @(posedge CLK); #1;
      check($sformatf("hold%0d_out_valid", i), 64'(out_valid), 64'd1);
      check($sformatf("hold%0d_in_ready", i),  64'(in_ready),  64'd0);
      check($sformatf("hold%0d_quotient", i),  64'(quotient),  64'd14);
      check($sformatf("hold%0d_remainder", i), 64'(remainder), 64'd2);
    end
    in_valid = 1'b0;
    compare_out("hold");
    finish_xfer("hold");
    run_vec("after_hold", vecs[1]);

    // Reset in the middle of CALC discards the operation.
    start_op("abort", vecs[0]);
    repeat (10) @(posedge CLK);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("abort");
    void'(sb.pop_front());
    @(posedge CLK); #1;
    check_reset_outputs("abort_held");
    rst_n = 1'b1;
    @(posedge CLK); #1;
    run_vec("post_abort", vecs[0]);

    v = model({32'd99, 32'hDEAD_BEEF}, 32'd100);
    run_vec("model_pt", v);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
